// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// master: stream source / memory side; slave: the loader.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// miniRV boot sequencer: streams a counted LE image into imem,
// then releases the CPU reset. start restarts the load at any time.
module prog_loader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  words_loaded
);

  localparam logic [31:0] MAXW = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [1:0]  bcnt;
  logic [23:0] asm_q;
  logic [31:0] count;
  logic [31:0] wcnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        acc;
  logic        last;
  logic [31:0] word;

  // busy mirrors HDR/DATA, which is exactly when bytes are taken
  assign bus.rx_ready  = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // a byte arriving with start is dropped
  assign acc  = bus.rx_valid && busy && !start;
  assign last = (bcnt == 2'd3);
  assign word = {bus.rx_data, asm_q};

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (1'b1)
      start: nxt = S_HDR;
      acc && last && state == S_HDR: begin
        if (word == 32'd0)
          nxt = S_RUN;
        else if (word > MAXW)
          nxt = S_ERR;
        else
          nxt = S_DATA;
      end
      acc && last && state == S_DATA: begin
        if (wcnt == count - 32'd1)
          nxt = S_RUN;
      end
      default: ;
    endcase
  end

  // state, counters, assembly/write registers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bcnt         <= 2'd0;
      asm_q        <= 24'd0;
      count        <= 32'd0;
      wcnt         <= 32'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cpu_rst_n    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 32'd0;
    end else begin
      state     <= nxt;
      busy      <= (nxt == S_HDR) || (nxt == S_DATA);
      done      <= (nxt == S_RUN);
      err       <= (nxt == S_ERR);
      cpu_rst_n <= (state == S_RUN) && !start;
      we_q      <= 1'b0;
      if (start) begin
        bcnt         <= 2'd0;
        wcnt         <= 32'd0;
        words_loaded <= 32'd0;
        asm_q        <= 24'd0;
      end else if (acc) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    asm_q[7:0]   <= bus.rx_data;
          2'd1:    asm_q[15:8]  <= bus.rx_data;
          2'd2:    asm_q[23:16] <= bus.rx_data;
          default: ;
        endcase
        if (last && state == S_HDR)
          count <= word;
        if (last && state == S_DATA) begin
          we_q         <= 1'b1;
          addr_q       <= BASE_ADDR + {wcnt[29:0], 2'b00};
          wdata_q      <= word;
          wcnt         <= wcnt + 32'd1;
          words_loaded <= words_loaded + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x0 and 0x100) share
// stimulus; writes are compared against images built by the bench.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_rst_n0, busy0, done0, err0;
  logic        cpu_rst_n1, busy1, done1, err1;
  logic [31:0] wl0, wl1;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq0[$];
  logic [63:0] wq1[$];

  prog_loader_if bus0 ();
  prog_loader_if bus1 ();

  assign bus0.rx_valid = rx_valid;
  assign bus0.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;
  assign bus1.rx_data  = rx_data;

  prog_loader #(.MEM_WORDS(1024), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
    .cpu_rst_n(cpu_rst_n0), .busy(busy0), .done(done0), .err(err0),
    .words_loaded(wl0)
  );

  prog_loader #(.MEM_WORDS(1024), .BASE_ADDR(32'h100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
    .cpu_rst_n(cpu_rst_n1), .busy(busy1), .done(done1), .err(err1),
    .words_loaded(wl1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) wq0.push_back({bus0.mem_addr, bus0.mem_wdata});
    if (bus1.mem_we === 1'b1) wq1.push_back({bus1.mem_addr, bus1.mem_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // header + words, little-endian, straight from the image format
  function automatic void build_image(input logic [31:0] w[$], output logic [7:0] img[$]);
    logic [31:0] n;
    img = {};
    n = w.size();
    for (int i = 0; i < 4; i++) img.push_back(8'(n >> (8 * i)));
    foreach (w[k])
      for (int i = 0; i < 4; i++) img.push_back(8'(w[k] >> (8 * i)));
  endfunction

  // gap_mode: 0 back-to-back, 1 alternate idle cycle, 2 random idles
  task automatic send(input logic [7:0] b[$], input int gap_mode);
    int n;
    int g;
    for (int i = 0; i < b.size(); i++) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b[i];
      n = 0;
      while (bus0.rx_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout byte %0d rx_ready=%b want 1", i, bus0.rx_ready);
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic v, input logic [7:0] d);
    @(negedge clk);
    start    = 1'b1;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #22;
    checks++;
    if ({cpu_rst_n0, busy0, done0, err0, wl0, bus0.rx_ready,
         bus0.mem_we, bus0.mem_addr, bus0.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cpu=%b busy=%b done=%b err=%b wl=%0d rdy=%b we=%b want all 0",
               cpu_rst_n0, busy0, done0, err0, wl0, bus0.rx_ready, bus0.mem_we);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.rx_ready !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got rdy=%b busy=%b want 0 0", bus0.rx_ready, busy0);
    end
  endtask

  task automatic check_two_words(input string tag);
    checks++;
    if (wq0.size() != 2 || wq1.size() != 2) begin
      errors++;
      $display("FAIL %s_count got %0d/%0d writes want 2", tag, wq0.size(), wq1.size());
    end else begin
      checks++;
      if (wq0[0] !== {32'h0, 32'h00100513} || wq0[1] !== {32'h4, 32'h00008067}) begin
        errors++;
        $display("FAIL %s_base0 got %h %h want 0/00100513 4/00008067", tag, wq0[0], wq0[1]);
      end
      checks++;
      if (wq1[0] !== {32'h100, 32'h00100513} || wq1[1] !== {32'h104, 32'h00008067}) begin
        errors++;
        $display("FAIL %s_base100 got %h %h want 100/00100513 104/00008067", tag, wq1[0], wq1[1]);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] img[$];
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
            8'h67, 8'h80, 8'h00, 8'h00};
    wq0.delete(); wq1.delete();
    pulse_start(1'b0, 8'h00);
    send(img, 0);
    @(negedge clk);
    checks++;
    if (bus0.mem_we !== 1'b1 || bus0.mem_addr !== 32'h4 || bus0.mem_wdata !== 32'h00008067) begin
      errors++;
      $display("FAIL basic_last_write got we=%b a=%h d=%h want 1 4 00008067",
               bus0.mem_we, bus0.mem_addr, bus0.mem_wdata);
    end
    checks++;
    if (cpu_rst_n0 !== 1'b0 || done0 !== 1'b1 || wl0 !== 32'd2) begin
      errors++;
      $display("FAIL basic_first_run got cpu=%b done=%b wl=%0d want 0 1 2", cpu_rst_n0, done0, wl0);
    end
    @(negedge clk);
    checks++;
    if (cpu_rst_n0 !== 1'b1 || bus0.mem_we !== 1'b0 || bus0.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got cpu=%b we=%b rdy=%b want 1 0 0",
               cpu_rst_n0, bus0.mem_we, bus0.rx_ready);
    end
    checks++;
    if (bus0.mem_addr !== 32'h4 || bus0.mem_wdata !== 32'h00008067) begin
      errors++;
      $display("FAIL basic_hold got a=%h d=%h want 4 00008067", bus0.mem_addr, bus0.mem_wdata);
    end
    check_two_words("basic");
  endtask

  task automatic test_gaps;
    logic [7:0] img[$];
    img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
            8'h67, 8'h80, 8'h00, 8'h00};
    wq0.delete(); wq1.delete();
    pulse_start(1'b0, 8'h00);
    send(img, 1);
    repeat (4) @(negedge clk);
    checks++;
    if (cpu_rst_n0 !== 1'b1 || done0 !== 1'b1 || wl0 !== 32'd2 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL gaps_status got cpu=%b done=%b wl=%0d busy=%b want 1 1 2 0",
               cpu_rst_n0, done0, wl0, busy0);
    end
    check_two_words("gaps");
  endtask

  task automatic test_err;
    logic [7:0] img[$];
    wq0.delete();
    pulse_start(1'b0, 8'h00);
    img = '{8'h00, 8'h04, 8'h00, 8'h00};
    send(img, 0);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL err_max_ok got busy=%b err=%b want 1 0", busy0, err0);
    end
    pulse_start(1'b0, 8'h00);
    img = '{8'h01, 8'h04, 8'h00, 8'h00};
    send(img, 0);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || bus0.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_enter got err=%b busy=%b done=%b rdy=%b want 1 0 0 0",
               err0, busy0, done0, bus0.rx_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || cpu_rst_n0 !== 1'b0 || wq0.size() != 0) begin
      errors++;
      $display("FAIL err_hold got err=%b cpu=%b writes=%0d want 1 0 0", err0, cpu_rst_n0, wq0.size());
    end
    pulse_start(1'b0, 8'h00);
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    send(img, 0);
    @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || cpu_rst_n0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_run got done=%b err=%b cpu=%b want 1 0 0", done0, err0, cpu_rst_n0);
    end
    @(negedge clk);
    checks++;
    if (cpu_rst_n0 !== 1'b1 || wl0 !== 32'd0) begin
      errors++;
      $display("FAIL zero_release got cpu=%b wl=%0d want 1 0", cpu_rst_n0, wl0);
    end
  endtask

  task automatic test_abort;
    logic [7:0]  img[$];
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    wq0.delete(); wq1.delete();
    pulse_start(1'b0, 8'h00);
    img = '{8'h02, 8'h00, 8'h00, 8'h00, w0[7:0], w0[15:8], w0[23:16], w0[31:24], 8'h5A};
    send(img, 2);
    pulse_start(1'b1, 8'hFF);
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1 || wl0 !== 32'd0 || bus0.rx_ready !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b wl=%0d rdy=%b done=%b want 1 0 1 0",
               busy0, wl0, bus0.rx_ready, done0);
    end
    checks++;
    if (wq0.size() != 1 || wq0[0] !== {32'h0, w0}) begin
      errors++;
      $display("FAIL abort_partial got %0d writes want 1 with %h", wq0.size(), w0);
    end
    img = '{8'h01, 8'h00, 8'h00, 8'h00, w1[7:0], w1[15:8], w1[23:16], w1[31:24]};
    send(img, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wq0.size() != 2 || wq1.size() != 2 ||
        wq0[1] !== {32'h0, w1} || wq1[1] !== {32'h100, w1}) begin
      errors++;
      $display("FAIL abort_reload got %0d/%0d writes want 2/2 last %h at 0 and 100",
               wq0.size(), wq1.size(), w1);
    end
    checks++;
    if (done0 !== 1'b1 || wl0 !== 32'd1 || cpu_rst_n0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_done got done=%b wl=%0d cpu=%b want 1 1 1", done0, wl0, cpu_rst_n0);
    end
  endtask

  task automatic test_restart_run;
    pulse_start(1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_rst_n0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL restart got cpu=%b done=%b busy=%b want 0 0 1", cpu_rst_n0, done0, busy0);
    end
  endtask

  task automatic test_random;
    logic [31:0] w[$];
    logic [7:0]  img[$];
    int          n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, 6);
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      build_image(w, img);
      wq0.delete(); wq1.delete();
      pulse_start(1'b0, 8'h00);
      send(img, 2);
      repeat (2) @(negedge clk);
      checks++;
      if (cpu_rst_n0 !== 1'b1 || done0 !== 1'b1 || wl0 !== 32'(n) || wl1 !== 32'(n)) begin
        errors++;
        $display("FAIL rand%0d_status got cpu=%b done=%b wl=%0d/%0d want 1 1 %0d",
                 it, cpu_rst_n0, done0, wl0, wl1, n);
      end
      checks++;
      if (wq0.size() != n || wq1.size() != n) begin
        errors++;
        $display("FAIL rand%0d_count got %0d/%0d writes want %0d", it, wq0.size(), wq1.size(), n);
      end
      for (int k = 0; k < n && k < wq0.size() && k < wq1.size(); k++) begin
        checks++;
        if (wq0[k] !== {32'(4 * k), w[k]} || wq1[k] !== {32'(32'h100 + 4 * k), w[k]}) begin
          errors++;
          $display("FAIL rand%0d_word%0d got %h / %h want data %h", it, k, wq0[k], wq1[k], w[k]);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] img[$];
    pulse_start(1'b0, 8'h00);
    img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(img, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rst_n0, busy0, done0, err0, wl0, bus0.rx_ready,
         bus0.mem_we, bus0.mem_addr, bus0.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b wl=%0d rdy=%b a=%h d=%h want all 0",
               busy0, wl0, bus0.rx_ready, bus0.mem_addr, bus0.mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.rx_ready !== 1'b0 || busy0 !== 1'b0 || cpu_rst_n0 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b cpu=%b want 0 0 0",
               bus0.rx_ready, busy0, cpu_rst_n0);
    end
    pulse_start(1'b0, 8'h00);
    @(negedge clk);
    checks++;
    if (bus0.rx_ready !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start got rdy=%b busy=%b want 1 1", bus0.rx_ready, busy0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_err();
    test_abort();
    test_restart_run();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
